// File: rtl/seg_scan_scheduler_pkg.sv
// Shared types and constants for the 7-segment scan scheduler.
// Blank patterns, FSM state encoding and anode decode helper.
package seg_scan_scheduler_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ON,
        ST_OFF
    } state_t;

    // Active-low one-cold anode pattern for digit i.
    function automatic logic [3:0] anode_sel(input logic [1:0] i);
        return ~(4'b0001 << i);
    endfunction

endpackage

// File: rtl/seg_next_digit.sv
// Circular next-enabled-digit finder (combinational).
// Ports: idx = current digit, mask = enable mask, nxt = next enabled, wrap = nxt <= idx.
module seg_next_digit (
    input  logic [1:0] idx,
    input  logic [3:0] mask,
    output logic [1:0] nxt,
    output logic       wrap
);

    logic [1:0] cand;
    logic       found;

    // Search idx+1, idx+2, idx+3, then idx itself (k=4 folds back to idx).
    always_comb begin
        nxt   = idx;
        cand  = idx;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = idx + 2'(k);
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        wrap = (nxt <= idx);
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Round-robin 4-digit 7-seg scan with anti-ghost blanking, PWM brightness, frame tick.
// Ports: clk/rst (sync, active-high), dig0..3/dp_in/digit_en/brightness in; anode/seg/dp/frame_tick out.
module seg_scan_scheduler
    import seg_scan_scheduler_pkg::*;
#(
    parameter int SLOT_CYCLES  = 10_000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] dig0,
    input  logic [6:0] dig1,
    input  logic [6:0] dig2,
    input  logic [6:0] dig3,
    input  logic [3:0] dp_in,
    input  logic [3:0] digit_en,
    input  logic [3:0] brightness,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    // Active window must split into 16 equal brightness steps.
    localparam int ON_STEP = (SLOT_CYCLES - BLANK_CYCLES) / 16;
    localparam int CW      = $clog2(SLOT_CYCLES);

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [6:0]    dig_lat, dig_lat_n;
    logic          dp_lat, dp_lat_n;
    logic [3:0]    bri_lat, bri_lat_n;

    logic [3:0]    anode_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic          tick_n;

    logic          load;
    logic          lit_n;
    logic [CW-1:0] lit_last;
    logic [1:0]    nd_idx;
    logic [1:0]    nd_nxt;
    logic          nd_wrap;
    logic [6:0]    dig_sel;

    // From IDLE, searching after digit 3 yields the lowest enabled digit.
    assign nd_idx = (state == ST_IDLE) ? 2'd3 : idx;

    seg_next_digit u_next (
        .idx  (nd_idx),
        .mask (digit_en),
        .nxt  (nd_nxt),
        .wrap (nd_wrap)
    );

    // Last lit count value for the brightness latched this slot.
    assign lit_last = CW'(BLANK_CYCLES + (int'(bri_lat) + 1) * ON_STEP - 1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        load    = 1'b0;
        tick_n  = 1'b0;
        if (state == ST_IDLE) begin
            cnt_n = '0;
            if (|digit_en) begin
                state_n = ST_BLANK;
                idx_n   = nd_nxt;
                load    = 1'b1;
                tick_n  = 1'b1;
            end
        end else if (cnt == SLOT_LAST) begin
            // Slot end wins over any in-slot transition.
            cnt_n = '0;
            if (|digit_en) begin
                state_n = ST_BLANK;
                idx_n   = nd_nxt;
                load    = 1'b1;
                tick_n  = nd_wrap;
            end else begin
                state_n = ST_IDLE;
            end
        end else begin
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST)
                        state_n = ST_ON;
                end
                ST_ON: begin
                    if (cnt == lit_last && bri_lat != 4'hF)
                        state_n = ST_OFF;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (idx_n)
            2'd0:    dig_sel = dig0;
            2'd1:    dig_sel = dig1;
            2'd2:    dig_sel = dig2;
            default: dig_sel = dig3;
        endcase
    end

    // Per-slot snapshot so mid-slot input changes never tear.
    assign dig_lat_n = load ? dig_sel : dig_lat;
    assign dp_lat_n  = load ? dp_in[idx_n] : dp_lat;
    assign bri_lat_n = load ? brightness : bri_lat;

    // Outputs are registered from next-state so they align with cnt.
    assign lit_n   = (state_n == ST_ON);
    assign anode_n = lit_n ? anode_sel(idx_n) : ANODE_OFF;
    assign seg_n   = lit_n ? dig_lat_n : SEG_BLANK;
    assign dp_n    = lit_n ? ~dp_lat_n : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= 2'd0;
            dig_lat    <= SEG_BLANK;
            dp_lat     <= 1'b0;
            bri_lat    <= 4'd0;
            anode      <= ANODE_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            dig_lat    <= dig_lat_n;
            dp_lat     <= dp_lat_n;
            bri_lat    <= bri_lat_n;
            anode      <= anode_n;
            seg        <= seg_n;
            dp         <= dp_n;
            frame_tick <= tick_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler (SLOT_CYCLES=40, BLANK_CYCLES=8).
// Table vectors indexed by edges since leaving reset, plus multi-cycle sequences.
module tb_seg_scan_scheduler;

    localparam logic [6:0] D0  = 7'h40;
    localparam logic [6:0] D1  = 7'h79;
    localparam logic [6:0] D2  = 7'h24;
    localparam logic [6:0] D3  = 7'h30;
    localparam logic [6:0] D1N = 7'h12;
    localparam logic [6:0] BL  = 7'h7F;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] dig0, dig1, dig2, dig3;
    logic [3:0] dp_in, digit_en, brightness;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp, frame_tick;

    int checks   = 0;
    int failures = 0;
    int t;

    always #5 clk = ~clk;

    seg_scan_scheduler #(
        .SLOT_CYCLES  (40),
        .BLANK_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .brightness (brightness),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    typedef struct {
        int         tid;
        int         tt;
        logic [3:0] an;
        logic [6:0] sg;
        logic       d;
        logic       tk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int tid, input int tt,
                                input logic [3:0] an, input logic [6:0] sg,
                                input logic d, input logic tk);
        vec_t v;
        v.tid = tid;
        v.tt  = tt;
        v.an  = an;
        v.sg  = sg;
        v.d   = d;
        v.tk  = tk;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [3:0] ea,
                       input logic [6:0] es, input logic ed, input logic et);
        checks++;
        if (anode !== ea || seg !== es || dp !== ed || frame_tick !== et) begin
            failures++;
            $display("FAIL %s t=%0d: got anode=%b seg=%h dp=%b tick=%b, want anode=%b seg=%h dp=%b tick=%b",
                     name, t, anode, seg, dp, frame_tick, ea, es, ed, et);
        end
    endtask

    // Reset with the given config, check reset outputs, release.
    task automatic start(input logic [3:0] en, input logic [3:0] bri,
                         input logic [3:0] dpi);
        rst        = 1'b1;
        digit_en   = en;
        brightness = bri;
        dp_in      = dpi;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 4'hF, BL, 1'b1, 1'b0);
        rst = 1'b0;
        t   = -1;
    endtask

    // t counts edges since release; t=0 is the first edge out of IDLE.
    task automatic adv_to(input int target);
        if (target > t) begin
            repeat (target - t) @(posedge clk);
            t = target;
            #1;
        end
    endtask

    task automatic count_pass(input string name, input logic [3:0] en,
                              input logic [3:0] bri, input int e0, input int e1,
                              input int e2, input int e3, input int etk);
        int c[4];
        int tk;
        start(en, bri, 4'h0);
        c  = '{0, 0, 0, 0};
        tk = 0;
        for (int i = 0; i < 160; i++) begin
            adv_to(i);
            for (int b = 0; b < 4; b++)
                if (!anode[b]) c[b]++;
            if (frame_tick) tk++;
        end
        checks++;
        if (c[0] != e0 || c[1] != e1 || c[2] != e2 || c[3] != e3 || tk != etk) begin
            failures++;
            $display("FAIL %s: got lit=%0d/%0d/%0d/%0d ticks=%0d, want lit=%0d/%0d/%0d/%0d ticks=%0d",
                     name, c[0], c[1], c[2], c[3], tk, e0, e1, e2, e3, etk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cur;
        rst        = 1'b1;
        dig0       = D0;
        dig1       = D1;
        dig2       = D2;
        dig3       = D3;
        dp_in      = 4'h0;
        digit_en   = 4'h0;
        brightness = 4'h0;
        t          = -1;

        // All digits, full brightness.
        add(1,   0, 4'hF, BL, 1'b1, 1'b1);
        add(1,   1, 4'hF, BL, 1'b1, 1'b0);
        add(1,   7, 4'hF, BL, 1'b1, 1'b0);
        add(1,   8, 4'hE, D0, 1'b1, 1'b0);
        add(1,  39, 4'hE, D0, 1'b1, 1'b0);
        add(1,  40, 4'hF, BL, 1'b1, 1'b0);
        add(1,  48, 4'hD, D1, 1'b1, 1'b0);
        add(1,  88, 4'hB, D2, 1'b1, 1'b0);
        add(1, 128, 4'h7, D3, 1'b1, 1'b0);
        add(1, 159, 4'h7, D3, 1'b1, 1'b0);
        add(1, 160, 4'hF, BL, 1'b1, 1'b1);
        add(1, 168, 4'hE, D0, 1'b1, 1'b0);
        // Digits 1 and 3, minimum brightness.
        add(2,   0, 4'hF, BL, 1'b1, 1'b1);
        add(2,   8, 4'hD, D1, 1'b1, 1'b0);
        add(2,   9, 4'hD, D1, 1'b1, 1'b0);
        add(2,  10, 4'hF, BL, 1'b1, 1'b0);
        add(2,  39, 4'hF, BL, 1'b1, 1'b0);
        add(2,  40, 4'hF, BL, 1'b1, 1'b0);
        add(2,  48, 4'h7, D3, 1'b1, 1'b0);
        add(2,  49, 4'h7, D3, 1'b1, 1'b0);
        add(2,  50, 4'hF, BL, 1'b1, 1'b0);
        add(2,  80, 4'hF, BL, 1'b1, 1'b1);
        add(2,  88, 4'hD, D1, 1'b1, 1'b0);
        // Single digit 0 with dp, mid brightness (lit cnt 8..23).
        add(6,   0, 4'hF, BL, 1'b1, 1'b1);
        add(6,   8, 4'hE, D0, 1'b0, 1'b0);
        add(6,  23, 4'hE, D0, 1'b0, 1'b0);
        add(6,  24, 4'hF, BL, 1'b1, 1'b0);
        add(6,  39, 4'hF, BL, 1'b1, 1'b0);
        add(6,  40, 4'hF, BL, 1'b1, 1'b1);
        add(6,  48, 4'hE, D0, 1'b0, 1'b0);

        cur = -1;
        foreach (vecs[i]) begin
            if (vecs[i].tid != cur) begin
                cur = vecs[i].tid;
                case (cur)
                    1:       start(4'hF, 4'hF, 4'h0);
                    2:       start(4'hA, 4'h0, 4'h0);
                    default: start(4'h1, 4'h7, 4'h1);
                endcase
            end
            adv_to(vecs[i].tt);
            chk($sformatf("vec%0d_t%0d", vecs[i].tid, vecs[i].tt),
                vecs[i].an, vecs[i].sg, vecs[i].d, vecs[i].tk);
        end

        // Lit-cycle and tick totals over one 160-cycle window.
        count_pass("count_all", 4'hF, 4'hF, 32, 32, 32, 32, 1);
        count_pass("count_1010", 4'hA, 4'h0, 0, 4, 0, 4, 2);

        // No tearing: dig1 changes mid-slot.
        start(4'hF, 4'hF, 4'h0);
        adv_to(48);
        chk("tear_before", 4'hD, D1, 1'b1, 1'b0);
        adv_to(60);
        dig1 = D1N;
        adv_to(61);
        chk("tear_mid", 4'hD, D1, 1'b1, 1'b0);
        adv_to(79);
        chk("tear_end", 4'hD, D1, 1'b1, 1'b0);
        adv_to(80);
        chk("tear_blank", 4'hF, BL, 1'b1, 1'b0);
        adv_to(208);
        chk("tear_next", 4'hD, D1N, 1'b1, 1'b0);
        dig1 = D1;

        // Disable during digit 2, finish slot, idle, re-enable digit 2.
        start(4'hF, 4'hF, 4'h0);
        adv_to(90);
        chk("dis_lit", 4'hB, D2, 1'b1, 1'b0);
        digit_en = 4'h0;
        adv_to(100);
        chk("dis_finish", 4'hB, D2, 1'b1, 1'b0);
        adv_to(119);
        chk("dis_last", 4'hB, D2, 1'b1, 1'b0);
        adv_to(120);
        chk("dis_idle", 4'hF, BL, 1'b1, 1'b0);
        adv_to(130);
        chk("dis_idle2", 4'hF, BL, 1'b1, 1'b0);
        digit_en = 4'h4;
        adv_to(131);
        chk("reen_tick", 4'hF, BL, 1'b1, 1'b1);
        adv_to(138);
        chk("reen_blank", 4'hF, BL, 1'b1, 1'b0);
        adv_to(139);
        chk("reen_lit", 4'hB, D2, 1'b1, 1'b0);

        // Reset pulse while lit, then restart from the lowest enabled digit.
        start(4'hF, 4'hF, 4'h0);
        adv_to(20);
        chk("rst_pre", 4'hE, D0, 1'b1, 1'b0);
        rst = 1'b1;
        adv_to(21);
        chk("rst_mid", 4'hF, BL, 1'b1, 1'b0);
        digit_en = 4'h6;
        adv_to(22);
        rst = 1'b0;
        t   = -1;
        adv_to(0);
        chk("rst_restart", 4'hF, BL, 1'b1, 1'b1);
        adv_to(8);
        chk("rst_lit", 4'hD, D1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
